// File: rtl/zx_clk_pkg.sv
// Shared definitions for the clock-enable generator: power-on FSM encoding,
// default widths and the POR counter width helper.
package zx_clk_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STRETCH   = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  localparam int DEF_DIV_W      = 8;
  localparam int DEF_POR_CYCLES = 1024;

  // POR counter width for a given stretch length: $clog2(POR_CYCLES+1).
  function automatic int por_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clk_enable_chan.sv
// One clock-enable channel: period counter, shadow/active divisor pair and
// registered rising/falling enable pulses.
module clk_enable_chan #(
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] DIV_INIT = '0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic             resync_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  output logic             ce_p_o,
  output logic             ce_n_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic             shv_q, shv_d;
  logic             ce_p_q, ce_p_d;
  logic             ce_n_q, ce_n_d;
  logic [DIV_W:0]   half_w;

  // One bit wider so D = 2^DIV_W-1 gives a correct mid-point.
  assign half_w = ({1'b0, act_q} + (DIV_W+1)'(1)) >> 1;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    shv_d  = shv_q;
    ce_p_d = 1'b0;
    ce_n_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (resync_i) begin
      cnt_d = '0;
      if (shv_q) begin
        act_d = shd_q;
        shv_d = 1'b0;
      end
    end else if (run_i && en_i) begin
      ce_p_d = (cnt_q == '0);
      ce_n_d = ({1'b0, cnt_q} == half_w);
      if (cnt_q == act_q) begin
        cnt_d = '0;
        if (shv_q) begin
          act_d = shd_q;
          shv_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    // A load that lands on a boundary stays pending for the next one.
    if (load_i) begin
      shd_d = div_i;
      shv_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= DIV_INIT;
      shd_q  <= DIV_INIT;
      shv_q  <= 1'b0;
      ce_p_q <= 1'b0;
      ce_n_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      shv_q  <= shv_d;
      ce_p_q <= ce_p_d;
      ce_n_q <= ce_n_d;
    end
  end

  assign ce_p_o = ce_p_q;
  assign ce_n_o = ce_n_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Clock-enable generator: sequences system reset from PLL lock and drives
// NUM_CH phase-aligned enable channels from the single system clock.
module clk_enable_gen
  import zx_clk_pkg::*;
#(
  parameter int                      NUM_CH     = 3,
  parameter int                      DIV_W      = DEF_DIV_W,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT   = {8'd1, 8'd3, 8'd1},
  parameter int                      POR_CYCLES = DEF_POR_CYCLES
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      pll_locked,
  input  logic [NUM_CH*DIV_W-1:0]   div_in,
  input  logic [NUM_CH-1:0]         div_load,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      resync,
  output logic [NUM_CH-1:0]         ce_p,
  output logic [NUM_CH-1:0]         ce_n,
  output logic                      sys_reset,
  output logic                      ready,
  output logic [1:0]                state_dbg
);

  localparam int               POR_W    = por_width(POR_CYCLES);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [POR_W-1:0] por_q, por_d;
  logic             sys_reset_q, ready_q;
  logic             run;

  // The lock-sampling cycle in WAIT_LOCK counts as the first stretch cycle.
  always_comb begin
    state_d = state_q;
    por_d   = por_q;
    if (!pll_locked) begin
      state_d = ST_WAIT_LOCK;
      por_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (POR_CYCLES <= 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STRETCH;
            por_d   = POR_W'(1);
          end
        end
        ST_STRETCH: begin
          if (por_q == POR_LAST) begin
            state_d = ST_RUN;
            por_d   = '0;
          end else begin
            por_d = por_q + POR_W'(1);
          end
        end
        ST_RUN: ;
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_WAIT_LOCK;
      por_q       <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      por_q       <= por_d;
      sys_reset_q <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  assign run       = (state_q == ST_RUN);
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign state_dbg = state_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_enable_chan #(
      .DIV_W   (DIV_W),
      .DIV_INIT(DIV_INIT[g*DIV_W +: DIV_W])
    ) u_chan (
      .clk_sys (clk_sys),
      .reset   (reset),
      .run_i   (run),
      .clr_i   (!pll_locked),
      .resync_i(resync && run),
      .en_i    (ch_en[g]),
      .div_i   (div_in[g*DIV_W +: DIV_W]),
      .load_i  (div_load[g]),
      .ce_p_o  (ce_p[g]),
      .ce_n_o  (ce_n[g])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: directed scenarios plus random traffic, checked
// cycle by cycle against a period/phase reference model.
module tb_clk_enable_gen;

  localparam int          NUM_CH      = 3;
  localparam int          DIV_W       = 8;
  localparam int          POR         = 16;
  localparam int          OW          = 2 * NUM_CH + 2;
  localparam logic [23:0] TB_DIV_INIT = {8'd0, 8'd3, 8'd1};

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic                    reset = 1'b1;
  logic                    pll_locked = 1'b1;
  logic                    resync = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_in = '0;
  logic [NUM_CH-1:0]       div_load = '0;
  logic [NUM_CH-1:0]       ch_en = '1;
  logic [NUM_CH-1:0]       ce_p, ce_n;
  logic                    sys_reset, ready;
  logic [1:0]              state_dbg;

  clk_enable_gen #(
    .NUM_CH    (NUM_CH),
    .DIV_W     (DIV_W),
    .DIV_INIT  (TB_DIV_INIT),
    .POR_CYCLES(POR)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pll_locked(pll_locked),
    .div_in    (div_in),
    .div_load  (div_load),
    .ch_en     (ch_en),
    .resync    (resync),
    .ce_p      (ce_p),
    .ce_n      (ce_n),
    .sys_reset (sys_reset),
    .ready     (ready),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel is a phase within a period of D+1 cycles; lock history is
  // a count of consecutive locked cycles since reset/lock loss.
  int m_phase[NUM_CH];
  int m_period[NUM_CH];
  int m_pend[NUM_CH];
  int m_lc = 0;

  task automatic model_step();
    logic [NUM_CH-1:0] ep, en;
    bit running;
    ep = '0;
    en = '0;
    running = (m_lc >= POR);
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_phase[i]  = 0;
        m_period[i] = int'(TB_DIV_INIT[i*DIV_W +: DIV_W]) + 1;
        m_pend[i]   = -1;
      end
      m_lc = 0;
    end else begin
      if (!pll_locked) begin
        for (int i = 0; i < NUM_CH; i++) m_phase[i] = 0;
      end else if (running && resync) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_phase[i] = 0;
          if (m_pend[i] >= 0) begin
            m_period[i] = m_pend[i];
            m_pend[i]   = -1;
          end
        end
      end else if (running) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_en[i]) begin
            ep[i] = (m_phase[i] == 0);
            en[i] = (m_phase[i] == m_period[i] / 2);
            m_phase[i] = (m_phase[i] + 1) % m_period[i];
            if (m_phase[i] == 0 && m_pend[i] >= 0) begin
              m_period[i] = m_pend[i];
              m_pend[i]   = -1;
            end
          end
        end
      end
      for (int i = 0; i < NUM_CH; i++)
        if (div_load[i]) m_pend[i] = int'(div_in[i*DIV_W +: DIV_W]) + 1;
      if (!pll_locked) m_lc = 0;
      else if (m_lc < POR) m_lc++;
    end
    exp_q.push_back({(m_lc >= POR), !(m_lc >= POR), en, ep});
  endtask

  // ---------------- pulse-gap monitor ----------------
  int cyc = 0;
  int last_p[NUM_CH];
  int last_gap[NUM_CH];
  int nofs = 0;
  int gq1[$];
  int gq2[$];

  // ---------------- driver ----------------
  task automatic tick();
    logic [OW-1:0] e;
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    cyc++;
    e = exp_q.pop_front();
    check_eq("ce_p", 32'(ce_p), 32'(e[NUM_CH-1:0]));
    check_eq("ce_n", 32'(ce_n), 32'(e[2*NUM_CH-1:NUM_CH]));
    check_eq("sys_reset", 32'(sys_reset), 32'(e[OW-2]));
    check_eq("ready", 32'(ready), 32'(e[OW-1]));
    for (int i = 0; i < NUM_CH; i++) begin
      if (ce_p[i]) begin
        last_gap[i] = cyc - last_p[i];
        last_p[i]   = cyc;
        if (i == 1) gq1.push_back(last_gap[i]);
        if (i == 2) gq2.push_back(last_gap[i]);
      end
    end
    if (ce_n[1]) nofs = cyc - last_p[1];
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n, p0, p2;
    for (int i = 0; i < NUM_CH; i++) begin
      last_p[i]   = 0;
      last_gap[i] = 0;
    end

    // 1. reset, POR stretch and first pulse
    repeat (5) tick();
    reset = 1'b0;
    wait_ready(n);
    check_eq("por_len", 32'(n), 32'(POR));
    tick();
    check_eq("first_cep", 32'(ce_p), 32'h7);

    // 2. initial divisors
    repeat (12) tick();
    check_eq("gap_ch0", 32'(last_gap[0]), 32'd2);
    check_eq("gap_ch1", 32'(last_gap[1]), 32'd4);
    check_eq("gap_ch2", 32'(last_gap[2]), 32'd1);
    check_eq("cen_ofs_ch1", 32'(nofs), 32'd2);

    // 3. mid-period reload on ch1
    n = 0;
    while (!ce_p[1] && n < 20) begin
      tick();
      n++;
    end
    div_in   = 24'(7) << 8;
    div_load = 3'b010;
    tick();
    div_load = '0;
    gq1.delete();
    repeat (24) tick();
    check_eq("reload_gap0", 32'(gq1[0]), 32'd4);
    check_eq("reload_gap1", 32'(gq1[1]), 32'd8);
    check_eq("reload_gap2", 32'(gq1[2]), 32'd8);

    // 4. freeze ch2 for 10 cycles
    div_in   = 24'(4) << 16;
    div_load = 3'b100;
    tick();
    div_load = '0;
    repeat (12) tick();
    ch_en = 3'b011;
    p0 = 0;
    p2 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      p0 += int'(ce_p[0]);
      p2 += int'(ce_p[2]);
    end
    check_eq("frozen_ch2_pulses", 32'(p2), 32'd0);
    check_eq("ch0_pulses_during_freeze", 32'(p0), 32'd5);
    gq2.delete();
    ch_en = 3'b111;
    repeat (8) tick();
    check_eq("ch2_gap_across_freeze", 32'(gq2[0]), 32'd15);

    // 5. one-cycle lock loss
    pll_locked = 1'b0;
    tick();
    check_eq("lockloss_ready", 32'(ready), 32'd0);
    check_eq("lockloss_cep", 32'(ce_p), 32'd0);
    pll_locked = 1'b1;
    wait_ready(n);
    check_eq("por_relock", 32'(n), 32'(POR));

    // 6. resync with a pending divisor
    repeat (3) tick();
    div_in   = 24'(2) << 8;
    div_load = 3'b010;
    tick();
    div_load = '0;
    resync   = 1'b1;
    tick();
    resync = 1'b0;
    tick();
    check_eq("resync_align", 32'(ce_p), 32'h7);
    repeat (7) tick();
    check_eq("resync_new_period", 32'(last_gap[1]), 32'd3);

    // 7. random traffic
    for (int k = 0; k < 400; k++) begin
      reset      = ($urandom_range(0, 199) == 0);
      pll_locked = ($urandom_range(0, 99) != 0);
      resync     = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        int r;
        ch_en[i]    = ($urandom_range(0, 7) != 0);
        div_load[i] = ($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 9);
        div_in[i*DIV_W +: DIV_W] = (r == 9) ? 8'd255 : 8'(r);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
